// File: rtl/furv_bus_pkg.sv
// furv_bus_pkg: shared SoC data-bus widths and arbiter state encoding
package furv_bus_pkg;
  localparam int ADDR_W = 30;
  localparam int DATA_W = 32;
  localparam int SEL_W  = DATA_W / 8;
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GNT      = 2'd1,
    ERR_WAIT = 2'd2
  } arb_state_t;
endpackage

// File: rtl/bus_timeout.sv
// bus_timeout: clearable cycle counter flagging a bus cycle that never acks
//   clk, rst : clock, async active-high reset
//   clr      : zero the count (has priority over en)
//   en       : count one cycle
//   expire   : count has reached TIMEOUT-1
module bus_timeout #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);
  logic [TO_W-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
  assign expire = cnt == TO_W'(TIMEOUT - 1);
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master round-robin arbiter with timeout for the shared SoC data bus
//   m0_*/m1_* : master-side cyc/we/addr/sel/data_out in, data_in/ack/err out
//   s_*       : slave-side cyc/we/addr/sel/data_out out, data_in/ack in
//   gnt       : one-hot current grant
module bus_arbiter #(
  parameter int ADDR_W  = furv_bus_pkg::ADDR_W,
  parameter int DATA_W  = furv_bus_pkg::DATA_W,
  parameter int SEL_W   = furv_bus_pkg::SEL_W,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_cyc,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [SEL_W-1:0]  m0_sel,
  input  logic [DATA_W-1:0] m0_data_out,
  output logic [DATA_W-1:0] m0_data_in,
  output logic              m0_ack,
  output logic              m0_err,
  input  logic              m1_cyc,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [SEL_W-1:0]  m1_sel,
  input  logic [DATA_W-1:0] m1_data_out,
  output logic [DATA_W-1:0] m1_data_in,
  output logic              m1_ack,
  output logic              m1_err,
  output logic              s_cyc,
  output logic              s_we,
  output logic [ADDR_W-1:0] s_addr,
  output logic [SEL_W-1:0]  s_sel,
  output logic [DATA_W-1:0] s_data_out,
  input  logic [DATA_W-1:0] s_data_in,
  input  logic              s_ack,
  output logic [1:0]        gnt
);
  import furv_bus_pkg::*;
  arb_state_t state;
  logic o, last, g, cyc_o, hit, to;
  assign g     = state == GNT;
  assign cyc_o = o ? m1_cyc : m0_cyc;
  // a same-cycle ack beats the timeout
  assign to    = g & cyc_o & ~s_ack & hit;
  bus_timeout #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) u_to (
    .clk(clk), .rst(rst), .clr(~g | s_ack), .en(g), .expire(hit)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      o     <= 1'b0;
      last  <= 1'b1;
    end else if (state == IDLE) begin
      if (m0_cyc | m1_cyc) begin
        state <= GNT;
        o     <= (m0_cyc & m1_cyc) ? ~last : m1_cyc;
      end
    end else if (!cyc_o) begin
      state <= IDLE;
      last  <= o;
    end else if (to) begin
      state <= ERR_WAIT;
    end
  always_comb begin
    s_cyc      = g & cyc_o & ~to;
    s_we       = g & (o ? m1_we : m0_we);
    s_addr     = g ? (o ? m1_addr : m0_addr) : '0;
    s_sel      = g ? (o ? m1_sel : m0_sel) : '0;
    s_data_out = g ? (o ? m1_data_out : m0_data_out) : '0;
    m0_data_in = (g & ~o) ? s_data_in : '0;
    m1_data_in = (g & o) ? s_data_in : '0;
    m0_ack     = g & ~o & s_ack & m0_cyc;
    m1_ack     = g & o & s_ack & m1_cyc;
    m0_err     = to & ~o;
    m1_err     = to & o;
    gnt        = g ? (o ? 2'b10 : 2'b01) : 2'b00;
  end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed self-checking bench for bus_arbiter
module tb_bus_arbiter;
  logic        clk = 0, rst = 1;
  logic        m0_cyc = 0, m0_we = 0, m1_cyc = 0, m1_we = 0, s_ack = 0;
  logic [29:0] m0_addr = '0, m1_addr = '0;
  logic [3:0]  m0_sel = '0, m1_sel = '0;
  logic [31:0] m0_data_out = '0, m1_data_out = '0, s_data_in = '0;
  logic [31:0] m0_data_in, m1_data_in, s_data_out;
  logic        m0_ack, m0_err, m1_ack, m1_err, s_cyc, s_we;
  logic [29:0] s_addr;
  logic [3:0]  s_sel;
  logic [1:0]  gnt;
  int n_chk = 0, n_fail = 0;

  bus_arbiter #(.TIMEOUT(8), .TO_W(8)) dut (
    .clk(clk), .rst(rst),
    .m0_cyc(m0_cyc), .m0_we(m0_we), .m0_addr(m0_addr), .m0_sel(m0_sel),
    .m0_data_out(m0_data_out), .m0_data_in(m0_data_in), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_cyc(m1_cyc), .m1_we(m1_we), .m1_addr(m1_addr), .m1_sel(m1_sel),
    .m1_data_out(m1_data_out), .m1_data_in(m1_data_in), .m1_ack(m1_ack), .m1_err(m1_err),
    .s_cyc(s_cyc), .s_we(s_we), .s_addr(s_addr), .s_sel(s_sel),
    .s_data_out(s_data_out), .s_data_in(s_data_in), .s_ack(s_ack), .gnt(gnt)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset;
    rst = 1;
    step;
    rst = 0;
  endtask

  initial begin
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_scyc", s_cyc, 0);
    chk("rst_ack", m0_ack, 0);
    chk("rst_err", m0_err, 0);
    step;
    rst = 0;
    // m0 alone writes 0xDEADBEEF to word 512
    m0_cyc = 1; m0_we = 1; m0_addr = 30'd512; m0_sel = 4'hf; m0_data_out = 32'hDEADBEEF;
    #1;
    chk("wr_lat_scyc", s_cyc, 0);
    step;
    chk("wr_scyc", s_cyc, 1);
    chk("wr_gnt", gnt, 2'b01);
    chk("wr_addr", s_addr, 512);
    chk("wr_data", s_data_out, 32'hDEADBEEF);
    chk("wr_we", s_we, 1);
    s_ack = 1;
    #1;
    chk("wr_ack", m0_ack, 1);
    step;
    m0_cyc = 0; s_ack = 0;
    #1;
    chk("wr_drop_scyc", s_cyc, 0);
    chk("wr_drop_ack", m0_ack, 0);
    step;
    chk("wr_idle", gnt, 0);
    // contention after reset: m0 first, then m1, then m0
    do_reset;
    m0_cyc = 1; m1_cyc = 1; m0_we = 0;
    step;
    chk("cont1_gnt", gnt, 2'b01);
    s_ack = 1; s_data_in = 32'h12345678;
    #1;
    chk("cont1_m0ack", m0_ack, 1);
    chk("cont1_m1ack", m1_ack, 0);
    chk("cont1_m1din", m1_data_in, 0);
    chk("cont1_m0din", m0_data_in, 32'h12345678);
    step;
    m0_cyc = 0; s_ack = 0;
    step;
    chk("cont_idle", gnt, 0);
    step;
    chk("cont2_gnt", gnt, 2'b10);
    m1_cyc = 0;
    step;
    m0_cyc = 1; m1_cyc = 1;
    step;
    chk("cont3_gnt", gnt, 2'b01);
    // m1 holds the bus for four led reads while m0 waits
    m0_cyc = 0; m1_we = 0; m1_addr = 30'd256;
    step;
    m0_cyc = 1;
    step;
    chk("hold_gnt", gnt, 2'b10);
    for (int i = 0; i < 4; i++) begin
      s_ack = 1; s_data_in = 32'hA000 + i;
      #1;
      chk("hold_m1ack", m1_ack, 1);
      chk("hold_m1din", m1_data_in, 32'hA000 + i);
      chk("hold_m0ack", m0_ack, 0);
      chk("hold_addr", s_addr, 256);
      step;
      chk("hold_still", gnt, 2'b10);
    end
    m1_cyc = 0; s_ack = 0;
    step;
    chk("hold_idle", gnt, 0);
    step;
    chk("hold_m0gnt", gnt, 2'b01);
    // timeout: no ack for 8 GNT cycles
    for (int i = 1; i < 8; i++) begin
      chk("to_noerr", m0_err, 0);
      chk("to_scyc", s_cyc, 1);
      step;
    end
    chk("to_err", m0_err, 1);
    chk("to_err_scyc", s_cyc, 0);
    chk("to_m1err", m1_err, 0);
    step;
    chk("ew_err", m0_err, 0);
    chk("ew_scyc", s_cyc, 0);
    chk("ew_gnt", gnt, 0);
    step;
    chk("ew_hold_gnt", gnt, 0);
    chk("ew_hold_scyc", s_cyc, 0);
    m0_cyc = 0;
    step;
    m0_cyc = 1;
    step;
    chk("ew_regnt", gnt, 2'b01);
    // ack on the cycle the count reaches TIMEOUT-1
    for (int i = 1; i < 8; i++) step;
    s_ack = 1;
    #1;
    chk("late_ack", m0_ack, 1);
    chk("late_noerr", m0_err, 0);
    chk("late_scyc", s_cyc, 1);
    step;
    s_ack = 0;
    #1;
    chk("late_after_err", m0_err, 0);
    chk("late_after_gnt", gnt, 2'b01);
    // async reset mid-transfer
    s_ack = 1;
    #1;
    chk("mid_scyc_pre", s_cyc, 1);
    #2;
    rst = 1;
    #1;
    chk("mid_scyc", s_cyc, 0);
    chk("mid_gnt", gnt, 0);
    chk("mid_ack", m0_ack, 0);
    step;
    rst = 0; m0_cyc = 0; s_ack = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
